// File: rtl/branch_prediction_unit_pkg.sv
// branch_prediction_unit_pkg: next-PC select codes, branch funct3 codes and outcome decode helpers
package branch_prediction_unit_pkg;
  localparam logic [2:0] NEXT_PC_FETCH_4   = 3'b000;
  localparam logic [2:0] NEXT_PC_FETCH_IMM = 3'b001;
  localparam logic [2:0] NEXT_PC_EXEC_IMM  = 3'b010;
  localparam logic [2:0] NEXT_PC_JALR      = 3'b011;
  localparam logic [2:0] NEXT_PC_EXEC_4    = 3'b100;
  localparam logic [2:0] NEXT_PC_TRAP      = 3'b101;
  localparam logic [2:0] FUNCT3_BRANCH_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BRANCH_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BRANCH_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BRANCH_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BRANCH_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BRANCH_BGEU = 3'b111;
  localparam logic [1:0] CNT_INIT_DEFAULT = 2'b01;
  function automatic logic branch_legal(input logic [2:0] f3);
    return f3[2:1] != 2'b01;
  endfunction
  // EQ/GE/GEU are taken when the ALU compare result is zero, the others when it is not
  function automatic logic taken_on_zero(input logic [2:0] f3);
    return f3 == FUNCT3_BRANCH_BEQ || f3 == FUNCT3_BRANCH_BGE || f3 == FUNCT3_BRANCH_BGEU;
  endfunction
endpackage

// File: rtl/branch_prediction_unit_bht.sv
// branch_history_table: 2-bit saturating counters, async read, saturating update on write
module branch_history_table
  import branch_prediction_unit_pkg::*;
#(
  parameter int         ENTRIES  = 64,
  parameter logic [1:0] CNT_INIT = CNT_INIT_DEFAULT,
  localparam int        IDX_W    = $clog2(ENTRIES)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [1:0]       o_rd_cnt,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);
  logic [1:0] r_cnt [ENTRIES];
  logic [1:0] w_cur;
  logic [1:0] w_nxt;
  assign w_cur = r_cnt[i_wr_idx];
  assign w_nxt = i_wr_taken ? (w_cur == 2'b11 ? 2'b11 : w_cur + 2'd1)
                            : (w_cur == 2'b00 ? 2'b00 : w_cur - 2'd1);
  assign o_rd_cnt = r_cnt[i_rd_idx];
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= CNT_INIT;
    else if (i_wr_en)
      r_cnt[i_wr_idx] <= w_nxt;
  end
endmodule

// File: rtl/branch_prediction_unit.sv
// branch_prediction_unit: branch resolve/predict, next-PC select, flush and branch statistics
module branch_prediction_unit
  import branch_prediction_unit_pkg::*;
#(
  parameter int         BHT_ENTRIES = 64,
  parameter int         XLEN        = 32,
  parameter logic [1:0] CNT_INIT    = CNT_INIT_DEFAULT,
  parameter int         STAT_W      = 32,
  localparam int        IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fetch_valid,
  input  logic              fetch_is_branch,
  input  logic [XLEN-1:0]   fetch_pc,
  output logic              predict_taken,
  input  logic              resolve_valid,
  input  logic [XLEN-1:0]   resolve_pc,
  input  logic              branch_enable,
  input  logic              jal_enable,
  input  logic              jalr_enable,
  input  logic              result_equal_zero,
  input  logic [2:0]        inst_funct3,
  input  logic              resolve_predicted_taken,
  output logic [2:0]        next_pc_select,
  output logic              flush,
  input  logic              stats_clear,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);
  logic [1:0]        w_cnt;
  logic              w_legal;
  logic              w_taken;
  logic              w_rb;
  logic              w_mp;
  logic              w_jal;
  logic              w_jalr;
  logic              w_unused;
  logic [STAT_W-1:0] r_branch_count;
  logic [STAT_W-1:0] r_mispredict_count;
  assign w_legal = branch_legal(inst_funct3);
  assign w_taken = branch_enable & w_legal & (taken_on_zero(inst_funct3) == result_equal_zero);
  assign w_rb    = resolve_valid & branch_enable & w_legal;
  assign w_mp    = w_rb & (w_taken != resolve_predicted_taken);
  assign w_jal   = resolve_valid & !branch_enable & jal_enable;
  assign w_jalr  = resolve_valid & !branch_enable & !jal_enable & jalr_enable;
  assign w_unused = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0], resolve_pc[XLEN-1:IDX_W+2],
                      resolve_pc[1:0], w_cnt[0]};
  branch_history_table #(.ENTRIES(BHT_ENTRIES), .CNT_INIT(CNT_INIT)) u_bht (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_rd_idx   (fetch_pc[IDX_W+1:2]),
    .o_rd_cnt   (w_cnt),
    .i_wr_en    (w_rb),
    .i_wr_idx   (resolve_pc[IDX_W+1:2]),
    .i_wr_taken (w_taken)
  );
  assign predict_taken = fetch_valid & fetch_is_branch & w_cnt[1];
  always_comb begin
    next_pc_select = w_mp          ? (w_taken ? NEXT_PC_EXEC_IMM : NEXT_PC_EXEC_4) :
                     w_jal         ? NEXT_PC_EXEC_IMM :
                     w_jalr        ? NEXT_PC_JALR :
                     predict_taken ? NEXT_PC_FETCH_IMM : NEXT_PC_FETCH_4;
    flush = w_mp | w_jal | w_jalr;
  end
  // counters stick at all-ones; clear takes precedence over counting
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (stats_clear) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_rb && !(&r_branch_count)) r_branch_count <= r_branch_count + STAT_W'(1);
      if (w_mp && !(&r_mispredict_count)) r_mispredict_count <= r_mispredict_count + STAT_W'(1);
    end
  end
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;
endmodule

// File: tb/tb_branch_prediction_unit.sv
// tb_branch_prediction_unit: vector table plus directed sequences, scoreboard-checked
module tb_branch_prediction_unit;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_valid, fetch_is_branch, resolve_valid;
  logic [31:0] fetch_pc, resolve_pc;
  logic        branch_enable, jal_enable, jalr_enable, result_equal_zero, resolve_predicted_taken;
  logic [2:0]  inst_funct3;
  logic        stats_clear;
  logic        predict_taken, flush;
  logic [2:0]  next_pc_select;
  logic [3:0]  branch_count, mispredict_count;

  typedef struct packed {
    logic fv; logic fb; logic [31:0] fpc;
    logic rv; logic [31:0] rpc; logic be; logic je; logic jre; logic rez; logic [2:0] f3; logic rpt;
    logic pt; logic [2:0] sel; logic fl; logic rb; logic mp;
  } vec_t;
  typedef struct packed { int tag; logic pt; logic [2:0] sel; logic fl; } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0;
  int   exp_bc = 0, exp_mc = 0;

  branch_prediction_unit #(.STAT_W(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .fetch_valid(fetch_valid), .fetch_is_branch(fetch_is_branch), .fetch_pc(fetch_pc),
    .predict_taken(predict_taken),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .branch_enable(branch_enable), .jal_enable(jal_enable), .jalr_enable(jalr_enable),
    .result_equal_zero(result_equal_zero), .inst_funct3(inst_funct3),
    .resolve_predicted_taken(resolve_predicted_taken),
    .next_pc_select(next_pc_select), .flush(flush),
    .stats_clear(stats_clear), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic add(input logic fv, fb, input logic [31:0] fpc, input logic rv,
                     input logic [31:0] rpc, input logic be, je, jre, rez, input logic [2:0] f3,
                     input logic rpt, pt, input logic [2:0] sel, input logic fl, rb, mp);
    vecs.push_back({fv, fb, fpc, rv, rpc, be, je, jre, rez, f3, rpt, pt, sel, fl, rb, mp});
  endtask

  task automatic drive(input logic fv, fb, input logic [31:0] fpc, input logic rv,
                       input logic [31:0] rpc, input logic be, je, jre, rez,
                       input logic [2:0] f3, input logic rpt);
    fetch_valid = fv; fetch_is_branch = fb; fetch_pc = fpc;
    resolve_valid = rv; resolve_pc = rpc; branch_enable = be; jal_enable = je;
    jalr_enable = jre; result_equal_zero = rez; inst_funct3 = f3; resolve_predicted_taken = rpt;
  endtask

  task automatic expect_out(input int tag, input logic pt, input logic [2:0] sel, input logic fl);
    sb.push_back('{tag, pt, sel, fl});
  endtask

  task automatic compare_out();
    exp_t e;
    #1;
    e = sb.pop_front();
    n_cmp++;
    if (predict_taken !== e.pt || next_pc_select !== e.sel || flush !== e.fl) begin
      n_bad++;
      $display("FAIL out tag=%0d: got pt=%b sel=%b flush=%b, want pt=%b sel=%b flush=%b",
               e.tag, predict_taken, next_pc_select, flush, e.pt, e.sel, e.fl);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic chk_stats(input string name);
    chk({name, "_bc"}, 32'(branch_count), exp_bc);
    chk({name, "_mc"}, 32'(mispredict_count), exp_mc);
  endtask

  task automatic count(input logic rb, mp);
    if (stats_clear) begin exp_bc = 0; exp_mc = 0; end
    else begin
      if (rb && exp_bc < 15) exp_bc++;
      if (mp && exp_mc < 15) exp_mc++;
    end
  endtask

  initial begin
    // fv fb fpc  rv rpc be je jre rez f3 rpt  pt sel fl  rb mp
    add(1,1,'h100, 0,0,    0,0,0,0,0,0, 0,3'b000,0, 0,0);
    add(0,0,0,     1,'h100,1,0,0,1,0,0, 0,3'b010,1, 1,1);
    add(1,1,'h100, 0,0,    0,0,0,0,0,0, 1,3'b001,0, 0,0);
    add(0,1,'h100, 0,0,    0,0,0,0,0,0, 0,3'b000,0, 0,0);
    add(1,0,'h100, 0,0,    0,0,0,0,0,0, 0,3'b000,0, 0,0);
    add(0,0,0,     1,'h100,1,0,0,1,0,1, 0,3'b000,0, 1,0);
    add(0,0,0,     1,'h100,1,0,0,1,0,1, 0,3'b000,0, 1,0);
    add(1,1,'h100, 0,0,    0,0,0,0,0,0, 1,3'b001,0, 0,0);
    add(1,1,'h100, 1,'h100,1,0,0,1,1,1, 1,3'b100,1, 1,1);
    add(1,1,'h100, 0,0,    0,0,0,0,0,0, 1,3'b001,0, 0,0);
    add(0,0,0,     1,'h100,1,0,0,1,1,0, 0,3'b000,0, 1,0);
    add(0,0,0,     1,'h100,1,0,0,0,5,0, 0,3'b000,0, 1,0);
    add(0,0,0,     1,'h100,1,0,0,1,6,1, 0,3'b100,1, 1,1);
    add(1,1,'h100, 0,0,    0,0,0,0,0,0, 0,3'b000,0, 0,0);
    add(0,0,0,     1,'h100,1,0,0,0,4,0, 0,3'b010,1, 1,1);
    add(1,1,'h100, 0,0,    0,0,0,0,0,0, 0,3'b000,0, 0,0);
    add(0,0,0,     1,'h80, 1,0,1,1,1,0, 0,3'b000,0, 1,0);
    add(0,0,0,     1,'h80, 0,0,1,0,0,0, 0,3'b011,1, 0,0);
    add(1,1,'h100, 1,'h80, 0,1,1,0,0,0, 0,3'b010,1, 0,0);
    add(0,0,0,     0,'h80, 1,0,1,1,0,0, 0,3'b000,0, 0,0);
    add(1,1,'h100, 1,'h100,1,0,0,1,2,1, 0,3'b000,0, 0,0);
    add(1,1,'h100, 1,'h100,1,0,0,0,3,0, 0,3'b000,0, 0,0);
    add(1,1,'h100, 0,0,    0,0,0,0,0,0, 0,3'b000,0, 0,0);
    add(0,0,0,     1,'h18, 1,0,0,1,7,1, 0,3'b000,0, 1,0);
    add(1,1,'h18,  0,0,    0,0,0,0,0,0, 1,3'b001,0, 0,0);
    add(0,0,0,     1,'h80, 1,0,0,0,1,1, 0,3'b000,0, 1,0);
    add(0,0,0,     1,'h80, 1,0,0,0,0,1, 0,3'b100,1, 1,1);
    add(0,0,0,     1,'h80, 1,0,0,1,5,0, 0,3'b010,1, 1,1);
    add(0,0,0,     1,'h80, 1,0,0,0,6,1, 0,3'b000,0, 1,0);
    add(0,0,0,     1,'h80, 1,0,0,0,7,0, 0,3'b000,0, 1,0);

    stats_clear = 1'b0;
    drive(0,0,0, 0,0,0,0,0,0,0,0);
    #3;
    expect_out(900, 0, 3'b000, 0);
    compare_out();
    chk_stats("reset");
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clock);
      chk_stats($sformatf("pre_vec%0d", k));
      drive(vecs[k].fv, vecs[k].fb, vecs[k].fpc, vecs[k].rv, vecs[k].rpc, vecs[k].be,
            vecs[k].je, vecs[k].jre, vecs[k].rez, vecs[k].f3, vecs[k].rpt);
      expect_out(k, vecs[k].pt, vecs[k].sel, vecs[k].fl);
      compare_out();
      count(vecs[k].rb, vecs[k].mp);
    end
    @(negedge clock);
    chk_stats("after_table");

    // same-cycle fetch and update of index 5: fetch sees the old counter
    drive(1,1,'h14, 1,'h14,1,0,0,1,0,0);
    expect_out(1000, 0, 3'b010, 1);
    compare_out();
    count(1, 1);
    @(negedge clock);
    drive(1,1,'h14, 0,0,0,0,0,0,0,0);
    expect_out(1001, 1, 3'b001, 0);
    compare_out();
    chk_stats("bypass");

    stats_clear = 1'b1;
    count(0, 0);
    @(negedge clock);
    stats_clear = 1'b0;
    chk_stats("clear");

    for (int i = 0; i < 16; i++) begin
      drive(0,0,0, 1,'h80,1,0,0,0,0,1);
      expect_out(1100 + i, 0, 3'b100, 1);
      compare_out();
      count(1, 1);
      @(negedge clock);
      if (i >= 14) chk_stats($sformatf("sat%0d", i));
    end

    stats_clear = 1'b1;
    drive(0,0,0, 1,'h80,1,0,0,0,0,1);
    count(1, 1);
    @(negedge clock);
    stats_clear = 1'b0;
    chk_stats("clear_wins");
    count(1, 1);
    @(negedge clock);
    chk_stats("after_clear");

    // reset asserted in the middle of a taken update to index 5
    drive(0,0,0, 1,'h14,1,0,0,1,0,1);
    #2 reset_n = 1'b0;
    #1;
    exp_bc = 0; exp_mc = 0;
    chk_stats("reset_mid");
    @(negedge clock);
    drive(1,1,'h18, 1,'h80,0,0,1,0,0,0);
    expect_out(1200, 0, 3'b011, 1);
    compare_out();
    @(negedge clock);
    reset_n = 1'b1;
    drive(0,0,0, 1,'h80,1,0,0,1,0,0);
    expect_out(1201, 0, 3'b010, 1);
    compare_out();
    count(1, 1);
    @(negedge clock);
    drive(1,1,'h80, 0,0,0,0,0,0,0,0);
    expect_out(1202, 1, 3'b001, 0);
    compare_out();
    @(negedge clock);
    drive(1,1,'h14, 0,0,0,0,0,0,0,0);
    expect_out(1203, 0, 3'b000, 0);
    compare_out();
    @(negedge clock);
    drive(1,1,'h18, 0,0,0,0,0,0,0,0);
    expect_out(1204, 0, 3'b000, 0);
    compare_out();
    chk_stats("post_reset");
    chk("sb_empty", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_prediction_unit.md
# branch_prediction_unit

Parametrised next-PC control unit for the pipelined core: resolves conditional branches, JAL and JALR at execute and predicts conditional branches at fetch. Prediction uses a table of 2-bit saturating counters indexed by PC. Drives the next-PC multiplexer select and the pipeline flush. Keeps saturating branch and mispredict statistics counters.

## Interface

Parameters:
- `BHT_ENTRIES`, 64: number of counters; power of two, ≥2. `IDX_W = $clog2(BHT_ENTRIES)`.
- `XLEN`, 32: PC width.
- `CNT_INIT`, 2'b01: counter value on reset (weakly not-taken).
- `STAT_W`, 32: width of the statistics counters.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `fetch_valid`  in  1  fetch stage holds a valid instruction.
- `fetch_is_branch`  in  1  predecoded conditional branch at fetch.
- `fetch_pc`  in  XLEN  fetch PC.
- `predict_taken`  out  1  prediction for the fetch instruction.
- `resolve_valid`  in  1  execute stage holds a valid instruction.
- `resolve_pc`  in  XLEN  execute PC.
- `branch_enable`, `jal_enable`, `jalr_enable`  in  1 each  execute instruction class.
- `result_equal_zero`  in  1  ALU result is zero.
- `inst_funct3`  in  3  funct3 of the execute instruction.
- `resolve_predicted_taken`  in  1  prediction carried down from fetch.
- `next_pc_select`  out  3  next-PC mux select.
- `flush`  out  1  kill the younger instructions in the pipeline.
- `stats_clear`  in  1  synchronous clear of the statistics counters.
- `branch_count`  out  STAT_W  number of resolved conditional branches.
- `mispredict_count`  out  STAT_W  number of mispredicted conditional branches.

## Operation

- Indexing: fetch index = `fetch_pc[IDX_W+1:2]`; update index = `resolve_pc[IDX_W+1:2]`.
- `predict_taken = fetch_valid & fetch_is_branch & bht[fetch_idx][1]`.
- Actual outcome (`taken`), when `branch_enable`:
  - EQ, GE, GEU: taken when `result_equal_zero`.
  - NE, LT, LTU: taken when `!result_equal_zero`.
  - funct3 010 and 011 are illegal branches: treated as not-taken, no table update, not counted, no flush.
- A resolved branch is `rb = resolve_valid & branch_enable & legal funct3`. It mispredicts when `mp = rb & (taken != resolve_predicted_taken)`.
- `next_pc_select` priority, first match wins (class priority is branch, then JAL, then JALR):
  - `mp & taken`: 3'b010, execute PC+imm; `flush`=1.
  - `mp & !taken`: 3'b100, execute PC+4; `flush`=1.
  - `resolve_valid & !branch_enable & jal_enable`: 3'b010; `flush`=1.
  - `resolve_valid & !branch_enable & !jal_enable & jalr_enable`: 3'b011, `{(rs1+imm)[XLEN-1:1],1'b0}`; `flush`=1.
  - `predict_taken`: 3'b001, fetch PC+imm; `flush`=0.
  - otherwise: 3'b000, fetch PC+4; `flush`=0.
- Select code 3'b101 is reserved for the future machine-mode trap vector and is never driven.
- Counter update on a clock edge with `rb`:
  - `taken`: increment, saturating at 2'b11.
  - `!taken`: decrement, saturating at 2'b00.
- Statistics, on each clock edge:
  - `stats_clear`: both counters go to 0. Clear wins over a simultaneous increment.
  - Otherwise `branch_count` += `rb` and `mispredict_count` += `mp`.
  - Each counter saturates at all-ones and does not wrap.

## Timing

- `predict_taken`, `next_pc_select` and `flush` are combinational. They have zero latency from their inputs.
- A table write becomes visible to fetch in the cycle after the update edge. There is no write-to-read bypass: when fetch and update hit the same index in one cycle, fetch sees the old value.
- Reset (`reset_n`=0, asynchronous, at any time including mid-update):
  - Every table entry goes to `CNT_INIT`.
  - `branch_count` and `mispredict_count` go to 0.
  - The combinational outputs follow their inputs.
  - With all inputs 0, `predict_taken`=0, `next_pc_select`=3'b000 and `flush`=0.
- There is no handshake and no stall input. The stage controller gates `resolve_valid` and `fetch_valid` for bubbles.

## Structure

- The shared config/constants header holds:
  - the `NEXT_PC_*` select encodings (000, 001, 010, 011, 100, reserved 101);
  - the `FUNCT3_BRANCH_*` codes;
  - `CNT_INIT`'s default value.
- One sub-module, `branch_history_table`, holds the counter array with:
  - one asynchronous read port (index to 2-bit value);
  - one write/update port (index, enable, `taken`), which does the saturating arithmetic;
  - async active-low reset to `CNT_INIT`.
- Outcome evaluation, select priority and the statistics counters live in the top module.

## Test plan

- Reset, then fetch branch at PC 0x100 → `predict_taken`=0, select 3'b000. Resolve BEQ at 0x100 with `result_equal_zero`=1 and predicted 0 → select 3'b010, `flush`=1, `mispredict_count`=1.
- Resolve the taken branch at PC 0x100 three times → counter goes 01→10→11→11. The next fetch of 0x100 gives `predict_taken`=1 and select 3'b001.
- Same-cycle fetch and resolve at index 5, counter 01, outcome taken → the fetch in that cycle predicts 0 and the fetch in the next cycle predicts 1.
- `branch_enable` and `jalr_enable` both high with BNE correctly predicted not-taken → select 3'b000 (branch wins, no redirect). JALR alone → select 3'b011, `flush`=1.
- Illegal funct3 3'b010 with `branch_enable` → select from fetch, `flush`=0, `branch_count` unchanged, table unchanged.
- Preload counters near saturation (STAT_W=4, 15 branches) plus one more branch → `branch_count`=15 and holds. `stats_clear` together with a branch → 0. Asserting `reset_n`=0 mid-update → all entries read `CNT_INIT`.
